// File: rtl/fcmp_issue.sv
// Issue/wait/response sequencer for an external float compare unit.
// Optional FCMP_NAN_EN: NaN operands bypass the comparator.
module fcmp_issue #(
  parameter int TAG_W       = 5,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             cmp_valid,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  output logic [2:0]       cmp_op,
  input  logic [31:0]      cmp_c_data,
  input  logic             cmp_c_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT_CYC - 1);

  state_t           st_q, st_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             res_q, res_d;
  logic             err_q, err_d;
  logic             bad_op;
  logic             nan_hit;
  logic             unused_data;

  assign bad_op      = req_op[2] & req_op[1];
  assign unused_data = ^cmp_c_data[31:1];

`ifdef FCMP_NAN_EN
  function automatic logic is_nan(input logic [31:0] v);
    return (&v[30:23]) & (|v[22:0]);
  endfunction
  assign nan_hit = is_nan(req_a) | is_nan(req_b);
`else
  assign nan_hit = 1'b0;
`endif

  always_comb begin
    st_d  = st_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    tag_d = tag_q;
    cnt_d = cnt_q;
    res_d = res_q;
    err_d = err_q;
    unique case (st_q)
      IDLE: begin
        if (req_valid) begin
          a_d   = req_a;
          b_d   = req_b;
          op_d  = req_op;
          tag_d = req_tag;
          cnt_d = 4'd0;
          res_d = 1'b0;
          err_d = 1'b0;
          if (bad_op) begin
            err_d = 1'b1;
            st_d  = RESP;
          end else if (nan_hit) begin
            res_d = (req_op == 3'b001);
            st_d  = RESP;
          end else begin
            st_d  = ISSUE;
          end
        end
      end
      ISSUE: st_d = WAIT;
      WAIT: begin
        // A strobe in the last allowed cycle still wins over the timeout
        if (cmp_c_valid) begin
          res_d = cmp_c_data[0];
          err_d = 1'b0;
          st_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d = 1'b0;
          err_d = 1'b1;
          st_d  = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      st_q  <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      res_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end

  assign req_ready  = (st_q == IDLE);
  assign cmp_valid  = (st_q == ISSUE);
  assign cmp_a      = a_q;
  assign cmp_b      = b_q;
  assign cmp_op     = op_q;
  assign rsp_valid  = (st_q == RESP);
  assign rsp_result = res_q;
  assign rsp_tag    = tag_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_fcmp_issue.sv
// Scoreboard bench for fcmp_issue with a 2-cycle comparator model.
// Honours FCMP_NAN_EN when computing expected bypass behaviour.
module tb_fcmp_issue;

  localparam int TAG_W = 5;

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [2:0]       req_op = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             cmp_valid;
  logic [31:0]      cmp_a;
  logic [31:0]      cmp_b;
  logic [2:0]       cmp_op;
  logic [31:0]      cmp_c_data;
  logic             cmp_c_valid;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic             rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  always #5 aclk = ~aclk;

  fcmp_issue #(.TAG_W(TAG_W), .TIMEOUT_CYC(15)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .req_tag     (req_tag),
    .cmp_valid   (cmp_valid),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .cmp_op      (cmp_op),
    .cmp_c_data  (cmp_c_data),
    .cmp_c_valid (cmp_c_valid),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_tag     (rsp_tag),
    .rsp_err     (rsp_err)
  );

  typedef struct packed {
    logic             res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_pulse = 0;
  logic auto_rdy = 1'b0;
  logic man_rdy = 1'b1;
  logic silent = 1'b0;
  logic inj = 1'b0;
  logic s1 = 1'b0, s2 = 1'b0, r1 = 1'b0, r2 = 1'b0;
  logic [30:0] junk = '0;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Map a float onto a signed integer line; +0 and -0 both land on 0
  function automatic longint fkey(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  function automatic logic ref_cmp(input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [2:0] op);
    longint ka, kb;
    if (is_nan(a) || is_nan(b)) return (op == 3'd1);
    ka = fkey(a);
    kb = fkey(b);
    case (op)
      3'd0: return ka == kb;
      3'd1: return ka != kb;
      3'd2: return ka <= kb;
      3'd3: return ka >= kb;
      3'd4: return ka < kb;
      3'd5: return ka > kb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [2:0] op,
                                  input logic [TAG_W-1:0] tag,
                                  input logic sil);
    exp_t e;
    e.tag = tag;
    e.res = 1'b0;
    e.err = 1'b0;
    if (op == 3'd6 || op == 3'd7) e.err = 1'b1;
`ifdef FCMP_NAN_EN
    else if (is_nan(a) || is_nan(b)) e.res = (op == 3'd1);
`endif
    else if (sil) e.err = 1'b1;
    else e.res = ref_cmp(a, b, op);
    return e;
  endfunction

  // External comparator: result strobe two edges after the start pulse
  always @(posedge aclk) begin
    s1 <= cmp_valid && !silent;
    r1 <= ref_cmp(cmp_a, cmp_b, cmp_op);
    s2 <= s1;
    r2 <= r1;
    junk <= 31'($urandom);
  end
  assign cmp_c_valid = s2 | inj;
  assign cmp_c_data  = {junk, r2};

  always @(posedge aclk) begin
    #1;
    rsp_ready = auto_rdy ? ($urandom_range(0, 3) != 0) : man_rdy;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge aclk) begin : monitor
    exp_t e;
    if (!areset) begin
      if (cmp_valid) n_pulse++;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got tag %0h expected none", rsp_tag);
        end else begin
          e = sb.pop_front();
          chk("rsp", {25'd0, rsp_result, rsp_tag, rsp_err}, {25'd0, e});
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [TAG_W-1:0] tag,
                      input logic sil);
    int w;
    w = 0;
    @(negedge aclk);
    while (!req_ready && w < 100) begin
      @(negedge aclk);
      w++;
    end
    if (!req_ready) begin
      chk("send_ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    silent = sil;
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    req_op = op;
    req_tag = tag;
    sb.push_back(mk_exp(a, b, op, tag, sil));
    @(posedge aclk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || !req_ready) && w < 300) begin
      @(negedge aclk);
      w++;
    end
    if (w >= 300) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [8];
    sp = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
           32'h40000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000};
    if ($urandom_range(0, 2) == 0) return sp[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  initial begin : main
    int p0, cnt, w;
    logic [TAG_W+1:0] snap;
    logic [31:0] ra, rb;
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_cmp_valid", {31'd0, cmp_valid}, 32'd0);
    chk("rst_cmp_a", cmp_a, 32'd0);
    chk("rst_cmp_b", cmp_b, 32'd0);
    chk("rst_rsp_bits", {24'd0, cmp_op, rsp_result, rsp_err, rsp_tag[2:0]}, 32'd0);
    chk("rst_rsp_tag", {27'd0, rsp_tag}, 32'd0);
    @(negedge aclk);
    areset = 1'b0;

    send(32'h3F800000, 32'h40000000, 3'd4, 5'd7, 1'b0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("lat_before_e3", {31'd0, rsp_valid}, 32'd0);
    @(posedge aclk);
    @(negedge aclk);
    chk("lat_after_e3", {31'd0, rsp_valid}, 32'd1);
    drain();

    send(32'h80000000, 32'h00000000, 3'd0, 5'd3, 1'b0);
    send(32'h80000000, 32'h00000000, 3'd5, 5'd4, 1'b0);
    drain();

    man_rdy = 1'b0;
    send(32'h3F800000, 32'h40000000, 3'd5, 5'd9, 1'b0);
    w = 0;
    while (!rsp_valid && w < 50) begin
      @(negedge aclk);
      w++;
    end
    chk("hold_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    snap = {rsp_result, rsp_tag, rsp_err};
    repeat (6) begin
      @(negedge aclk);
      chk("hold_stable", {22'd0, rsp_valid, req_ready, rsp_result, rsp_tag, rsp_err},
          {22'd0, 1'b1, 1'b0, snap});
    end
    man_rdy = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    @(posedge aclk);
    @(negedge aclk);
    chk("hold_release_idle", {30'd0, req_ready, rsp_valid}, 32'd2);
    drain();

    p0 = n_pulse;
    send(32'h40000000, 32'h3F800000, 3'd2, 5'd2, 1'b1);
    cnt = 0;
    @(negedge aclk);
    do begin
      @(negedge aclk);
      cnt++;
    end while (!rsp_valid && cnt < 40);
    chk("timeout_cycles", cnt, 32'd16);
    chk("timeout_err", {30'd0, rsp_err, rsp_result}, 32'd2);
    drain();
    chk("timeout_pulses", n_pulse - p0, 32'd1);

    p0 = n_pulse;
    send($urandom, $urandom, 3'd7, 5'd4, 1'b0);
    @(negedge aclk);
    chk("badop_immediate", {31'd0, rsp_valid}, 32'd1);
    drain();
    chk("badop_pulses", n_pulse - p0, 32'd0);

    for (int k = 0; k < 2; k++) begin
      p0 = n_pulse;
      send(32'h7FC00000, 32'h3F800000, 3'(k), 5'(10 + k), 1'b0);
      drain();
`ifdef FCMP_NAN_EN
      chk("nan_pulses", n_pulse - p0, 32'd0);
`else
      chk("nan_pulses", n_pulse - p0, 32'd1);
`endif
    end

    send(32'h3F800000, 32'h40000000, 3'd4, 5'd5, 1'b1);
    repeat (4) @(negedge aclk);
    #2 areset = 1'b1;
    sb.delete();
    #2 areset = 1'b0;
    silent = 1'b0;
    @(negedge aclk);
    inj = 1'b1;
    @(negedge aclk);
    inj = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      chk("stale_ignored", {30'd0, rsp_valid, req_ready}, 32'd1);
    end
    send(32'hC0000000, 32'hBF800000, 3'd4, 5'd21, 1'b0);
    drain();

    auto_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra = pick();
      rb = ($urandom_range(0, 4) == 0) ? ra : pick();
      send(ra, rb, 3'($urandom_range(0, 7)), 5'($urandom),
           ($urandom_range(0, 15) == 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fcmp_issue.md
FCMP_ISSUE -- requirements
Module: fcmp_issue

Interface
REQ-001 SHALL have parameter TAG_W, default 5: width of the destination tag carried with each request.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 15: maximum WAIT cycles before the block aborts a compare.
REQ-003 aclk  input  1  the single clock; all state changes on its rising edge.
REQ-004 areset  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  1  upstream request present.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_a, req_b  input  32 each  IEEE-754 single operands.
REQ-008 req_op  input  3  compare code: 000 EQ, 001 NE, 010 LE, 011 GE, 100 LT, 101 GT.
REQ-009 req_tag  input  TAG_W  destination tag.
REQ-010 cmp_valid  output  1  one-cycle start pulse to the comparator data_valid.
REQ-011 cmp_a, cmp_b  output  32 each  operands to the comparator.
REQ-012 cmp_op  output  3  op to the comparator.
REQ-013 cmp_c_data  input  32  comparator result; only bit 0 is used.
REQ-014 cmp_c_valid  input  1  comparator result strobe.
REQ-015 rsp_valid  output  1  result present downstream.
REQ-016 rsp_ready  input  1  downstream consumes the result.
REQ-017 rsp_result  output  1  compare outcome.
REQ-018 rsp_tag  output  TAG_W  echoed tag.
REQ-019 rsp_err  output  1  result invalid (timeout or illegal op).

Function
REQ-020 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: on req_valid, SHALL latch a, b, op, tag and go to ISSUE; if op is 110 or 111, SHALL go to RESP instead, with rsp_result=0 and rsp_err=1, and SHALL NOT issue to the comparator.
REQ-022 ISSUE: cmp_valid=1 for exactly one cycle, then WAIT; the WAIT counter SHALL clear on ISSUE entry.
REQ-023 cmp_a, cmp_b and cmp_op SHALL hold the latched values, unchanged, from ISSUE until WAIT exits.
REQ-024 WAIT: on cmp_c_valid=1, SHALL capture cmp_c_data[0] into rsp_result, set rsp_err=0 and go to RESP.
REQ-025 WAIT: the 4-bit counter SHALL increment each cycle; when it reaches TIMEOUT_CYC with no strobe, SHALL go to RESP with rsp_result=0 and rsp_err=1.
REQ-026 cmp_c_valid SHALL be ignored in IDLE, ISSUE and RESP.
REQ-027 RESP: rsp_valid=1, and rsp_result, rsp_tag and rsp_err SHALL be stable; on rsp_ready=1, SHALL go to IDLE.
REQ-028 Nominal latency: the accept edge is E0; rsp_valid SHALL be high in the cycle after E3.
REQ-029 After rsp_ready=1 at an edge, a new request SHALL be acceptable no earlier than the following edge; throughput is at most 1 compare per 5 cycles.

Reset
REQ-030 areset SHALL immediately force state IDLE and clear the counter; all outputs SHALL go to 0 except req_ready=1.
REQ-031 A reset during ISSUE, WAIT or RESP SHALL drop the in-flight request with no response; a later stale cmp_c_valid SHALL be ignored per REQ-026.

Configuration
REQ-032 Macro FCMP_NAN_EN defined: in IDLE, an operand with exponent 0xFF and nonzero mantissa SHALL bypass the comparator and go to RESP next cycle, with rsp_result=(op==NE), rsp_err=0 and no cmp_valid pulse.
REQ-033 FCMP_NAN_EN undefined: NaN operands SHALL be issued to the comparator unchanged, like any other value.

Verification
REQ-034 a=0x3F800000, b=0x40000000, op=LT, tag=7 -> rsp_valid in the cycle after E3, rsp_result=1, rsp_tag=7, rsp_err=0.
REQ-035 a=0x80000000, b=0x00000000, op=EQ -> rsp_result=1; the same pair with op=GT -> rsp_result=0.
REQ-036 rsp_ready held 0 for 6 cycles in RESP -> rsp_* stable and req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-037 cmp_c_valid tied 0 -> rsp_err=1 and rsp_result=0 after 15 WAIT cycles; op=111 -> immediate error and no cmp_valid pulse.
REQ-038 a=0x7FC00000, b=0x3F800000: op=EQ -> 0, op=NE -> 1, with no cmp_valid when FCMP_NAN_EN is defined; a cmp_valid pulse when it is undefined.
REQ-039 areset pulsed during WAIT, then cmp_c_valid=1 -> no rsp_valid, req_ready=1, and the next request completes normally.
